ac97_cmd_arbiter: RTL and testbench

AC97_CMD_ARBITER -- requirements
Module: ac97_cmd_arbiter

---
 rtl/ac97_cmd_arbiter.sv | 148 ++++++++++++++
 tb/tb_ac97_cmd_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_cmd_arbiter.sv
// rtl/ac97_cmd_arbiter.sv - round-robin arbiter presenting codec register commands to an AC97 link
module ac97_cmd_arbiter #(
  parameter int HOLD_FRAMES = 2,
  parameter int RD_TIMEOUT  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_ready,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_addr,
  input  logic [47:0] req_data,
  output logic [2:0]  req_ack,
  output logic [7:0]  command_address,
  output logic [15:0] command_data,
  output logic        command_valid,
  input  logic        status_valid,
  input  logic [7:0]  status_address,
  input  logic [15:0] status_data,
  output logic [15:0] rd_data,
  output logic [2:0]  rd_done,
  output logic        rd_timeout,
  output logic        busy
);

  localparam int MAX_FRAMES = (HOLD_FRAMES > RD_TIMEOUT) ? HOLD_FRAMES : RD_TIMEOUT;
  localparam int CW = $clog2(MAX_FRAMES + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_FRAMES);
  localparam logic [CW-1:0] RDTO_C = CW'(RD_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_STATUS} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_last_grant, w_last_grant_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]    r_addr, w_addr_nxt;
  logic [15:0]   r_data, w_data_nxt;
  logic [15:0]   r_rd_data, w_rd_data_nxt;
  logic [2:0]    r_ack, w_ack_nxt;
  logic [2:0]    r_done, w_done_nxt;
  logic          r_tmo, w_tmo_nxt;
  logic          w_found;
  logic [1:0]    w_pick;
  logic [1:0]    w_cand [3];

  assign w_cnt_inc = r_cnt + 1'b1;

  // Search order starts just after the previous winner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_cand  = '{2'd0, 2'd1, 2'd2};
    case (r_last_grant)
      2'd0:    w_cand = '{2'd1, 2'd2, 2'd0};
      2'd1:    w_cand = '{2'd2, 2'd0, 2'd1};
      default: w_cand = '{2'd0, 2'd1, 2'd2};
    endcase
    for (int k = 0; k < 3; k++) begin
      if (!w_found && req_valid[w_cand[k]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[k];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_rd_data_nxt    = r_rd_data;
    w_ack_nxt        = 3'b000;
    w_done_nxt       = 3'b000;
    w_tmo_nxt        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_addr_nxt       = req_addr[{w_pick, 3'b000} +: 8];
          w_data_nxt       = req_data[{w_pick, 4'b0000} +: 16];
          w_ack_nxt        = 3'b001 << w_pick;
          w_last_grant_nxt = w_pick;
          w_cnt_nxt        = '0;
          w_state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        if (frame_ready) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == HOLD_C) begin
            w_cnt_nxt   = '0;
            w_state_nxt = r_addr[7] ? WAIT_STATUS : IDLE;
          end
        end
      end
      WAIT_STATUS: begin
        // A matching status beats a timeout landing on the same cycle.
        if (status_valid && (status_address[6:0] == r_addr[6:0])) begin
          w_rd_data_nxt = status_data;
          w_done_nxt    = 3'b001 << r_last_grant;
          w_state_nxt   = IDLE;
        end else if (frame_ready) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == RDTO_C) begin
            w_rd_data_nxt = 16'hFFFF;
            w_tmo_nxt     = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 2'd2;
      r_cnt        <= '0;
      r_addr       <= 8'h80;
      r_data       <= 16'h0000;
      r_rd_data    <= 16'h0000;
      r_ack        <= 3'b000;
      r_done       <= 3'b000;
      r_tmo        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_ack        <= w_ack_nxt;
      r_done       <= w_done_nxt;
      r_tmo        <= w_tmo_nxt;
    end
  end

  assign command_valid   = (r_state == ISSUE);
  assign command_address = command_valid ? r_addr : 8'h80;
  assign command_data    = command_valid ? r_data : 16'h0000;
  assign busy            = (r_state != IDLE);
  assign req_ack         = r_ack;
  assign rd_done         = r_done;
  assign rd_timeout      = r_tmo;
  assign rd_data         = r_rd_data;

endmodule

// File: tb/tb_ac97_cmd_arbiter.sv
// tb/tb_ac97_cmd_arbiter.sv - self-checking bench for ac97_cmd_arbiter
module tb_ac97_cmd_arbiter;
  localparam int HOLD = 2;
  localparam int RDTO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_ready = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [23:0] req_addr = '0;
  logic [47:0] req_data = '0;
  logic [2:0]  req_ack;
  logic [7:0]  command_address;
  logic [15:0] command_data;
  logic        command_valid;
  logic        status_valid = 1'b0;
  logic [7:0]  status_address = '0;
  logic [15:0] status_data = '0;
  logic [15:0] rd_data;
  logic [2:0]  rd_done;
  logic        rd_timeout;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int m_last = 2;

  ac97_cmd_arbiter #(.HOLD_FRAMES(HOLD), .RD_TIMEOUT(RDTO)) dut (
    .clock(clock), .reset(reset), .frame_ready(frame_ready),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ack(req_ack),
    .command_address(command_address), .command_data(command_data), .command_valid(command_valid),
    .status_valid(status_valid), .status_address(status_address), .status_data(status_data),
    .rd_data(rd_data), .rd_done(rd_done), .rd_timeout(rd_timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  mask;
    int          exp_idx;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [12];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_frame;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic pulse_status(input logic [7:0] a, input logic [15:0] d, input logic fr);
    status_valid   = 1'b1;
    status_address = a;
    status_data    = d;
    frame_ready    = fr;
    tick();
    status_valid = 1'b0;
    frame_ready  = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = 3'b000;
    frame_ready = 1'b0;
    status_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_last = 2;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [15:0] d);
    req_addr[8*i +: 8]  = a;
    req_data[16*i +: 16] = d;
  endtask

  task automatic do_grant(input logic [2:0] mask, input int exp, input logic [7:0] ea,
                          input logic [15:0] ed, input bit keep);
    int n;
    req_valid = mask;
    tick();
    n = 1;
    while (req_ack == 3'b000 && n < 8) begin
      tick();
      n++;
    end
    check("grant_ack", 32'(req_ack), 32'(1) << exp);
    check("cmd_valid", 32'(command_valid), 32'd1);
    check("cmd_addr", 32'(command_address), 32'(ea));
    check("cmd_data", 32'(command_data), 32'(ed));
    if (!keep) req_valid = 3'b000;
  endtask

  task automatic hold_issue(input logic is_read, input int max_gap);
    for (int f = 0; f < HOLD; f++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      pulse_frame();
      if (f < HOLD - 1) begin
        check("cmd_held", 32'(command_valid), 32'd1);
      end else begin
        check("cmd_released", 32'(command_valid), 32'd0);
        check("busy_after_issue", 32'(busy), 32'(is_read));
        check("no_back_to_back_grant", 32'(req_ack), 32'd0);
        if (!is_read) check("idle_addr", 32'(command_address), 32'h80);
      end
    end
  endtask

  initial begin
    logic [2:0]  mask;
    logic [7:0]  a;
    logic [7:0]  nm;
    logic [15:0] sd;
    int          exp;
    int          scen;
    int          k;

    do_reset();
    check("rst_cmd_valid", 32'(command_valid), 32'd0);
    check("rst_cmd_addr", 32'(command_address), 32'h80);
    check("rst_cmd_data", 32'(command_data), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_done", 32'(rd_done), 32'd0);
    check("rst_tmo", 32'(rd_timeout), 32'd0);

    // single write from requester 0
    for (int i = 0; i < 3; i++) set_req(i, 8'h02 + 8'(2*i), 16'h0808 + 16'(16'h0101 * i));
    do_grant(3'b001, 0, 8'h02, 16'h0808, 0);
    hold_issue(1'b0, 0);
    check("wr_no_done", 32'(rd_done), 32'd0);

    // round-robin table from reset
    tbl[0]  = '{3'b111, 0, 8'h02, 16'h0808};
    tbl[1]  = '{3'b111, 1, 8'h04, 16'h0909};
    tbl[2]  = '{3'b111, 2, 8'h06, 16'h0A0A};
    tbl[3]  = '{3'b111, 0, 8'h02, 16'h0808};
    tbl[4]  = '{3'b100, 2, 8'h06, 16'h0A0A};
    tbl[5]  = '{3'b011, 0, 8'h02, 16'h0808};
    tbl[6]  = '{3'b110, 1, 8'h04, 16'h0909};
    tbl[7]  = '{3'b101, 2, 8'h06, 16'h0A0A};
    tbl[8]  = '{3'b001, 0, 8'h02, 16'h0808};
    tbl[9]  = '{3'b010, 1, 8'h04, 16'h0909};
    tbl[10] = '{3'b011, 0, 8'h02, 16'h0808};
    tbl[11] = '{3'b011, 1, 8'h04, 16'h0909};
    do_reset();
    for (int r = 0; r < 12; r++) begin
      do_grant(tbl[r].mask, tbl[r].exp_idx, tbl[r].exp_addr, tbl[r].exp_data, tbl[r].mask == 3'b111);
      hold_issue(1'b0, 1);
    end

    // read completed by a matching status one frame after issue
    set_req(0, 8'h80, 16'h0000);
    do_grant(3'b001, 0, 8'h80, 16'h0000, 0);
    hold_issue(1'b1, 0);
    pulse_frame();
    check("rd_wait_busy", 32'(busy), 32'd1);
    pulse_status(8'h00, 16'h6150, 1'b0);
    check("rd_done", 32'(rd_done), 32'b001);
    check("rd_data", 32'(rd_data), 32'h6150);
    check("rd_no_tmo", 32'(rd_timeout), 32'd0);
    check("rd_idle", 32'(busy), 32'd0);
    tick();
    check("rd_done_pulse", 32'(rd_done), 32'd0);
    check("rd_data_held", 32'(rd_data), 32'h6150);

    // read timeout; status seen in ISSUE and non-matching status ignored
    do_grant(3'b001, 0, 8'h80, 16'h0000, 0);
    pulse_status(8'h00, 16'hDEAD, 1'b0);
    check("issue_status_ignored", 32'(rd_done), 32'd0);
    check("issue_status_valid", 32'(command_valid), 32'd1);
    hold_issue(1'b1, 0);
    pulse_status(8'h1C, 16'h1111, 1'b0);
    check("nomatch_ignored", 32'(rd_done), 32'd0);
    check("nomatch_busy", 32'(busy), 32'd1);
    for (int f = 1; f < RDTO; f++) begin
      pulse_frame();
      check("no_early_tmo", 32'(rd_timeout), 32'd0);
    end
    pulse_frame();
    check("tmo_pulse", 32'(rd_timeout), 32'd1);
    check("tmo_data", 32'(rd_data), 32'hFFFF);
    check("tmo_no_done", 32'(rd_done), 32'd0);
    check("tmo_idle", 32'(busy), 32'd0);
    tick();
    check("tmo_pulse_end", 32'(rd_timeout), 32'd0);

    // status coincident with the timeout frame wins
    do_grant(3'b001, 0, 8'h80, 16'h0000, 0);
    hold_issue(1'b1, 0);
    repeat (RDTO - 1) pulse_frame();
    pulse_status(8'h80, 16'h1234, 1'b1);
    check("race_done", 32'(rd_done), 32'b001);
    check("race_no_tmo", 32'(rd_timeout), 32'd0);
    check("race_data", 32'(rd_data), 32'h1234);
    pulse_status(8'h00, 16'hBEEF, 1'b0);
    check("idle_status_ignored", 32'(rd_done), 32'd0);
    check("idle_status_data", 32'(rd_data), 32'h1234);

    // reset during ISSUE of requester 1
    do_reset();
    set_req(0, 8'h20, 16'h1111);
    set_req(1, 8'h10, 16'h2222);
    do_grant(3'b010, 1, 8'h10, 16'h2222, 0);
    pulse_frame();
    reset = 1'b1;
    tick();
    check("rst_issue_valid", 32'(command_valid), 32'd0);
    check("rst_issue_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    m_last = 2;
    do_grant(3'b011, 0, 8'h20, 16'h1111, 0);
    hold_issue(1'b0, 0);

    // reset during WAIT_STATUS
    set_req(2, 8'h8A, 16'h0000);
    do_grant(3'b100, 2, 8'h8A, 16'h0000, 0);
    hold_issue(1'b1, 0);
    pulse_frame();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_wait_done", 32'(rd_done), 32'd0);
    check("rst_wait_tmo", 32'(rd_timeout), 32'd0);
    check("rst_wait_data", 32'(rd_data), 32'h0);
    check("rst_wait_busy", 32'(busy), 32'd0);

    // randomized transactions against a transaction-level model
    do_reset();
    for (int t = 0; t < 60; t++) begin
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) set_req(i, 8'($urandom), 16'($urandom));
      exp = -1;
      for (int s = 1; s <= 3; s++)
        if (exp < 0 && mask[(m_last + s) % 3]) exp = (m_last + s) % 3;
      a = req_addr[8*exp +: 8];
      do_grant(mask, exp, a, req_data[16*exp +: 16], 0);
      m_last = exp;
      hold_issue(a[7], 2);
      if (!a[7]) begin
        check("rnd_wr_no_done", 32'(rd_done), 32'd0);
      end else begin
        scen = $urandom_range(0, 2);
        sd = 16'($urandom);
        nm = {1'($urandom), a[6:0] ^ 7'($urandom_range(1, 127))};
        if (scen == 0) begin
          k = $urandom_range(0, RDTO - 1);
          repeat (k) begin
            if ($urandom_range(0, 1) == 1) pulse_status(nm, 16'($urandom), 1'b0);
            pulse_frame();
          end
          pulse_status({1'($urandom), a[6:0]}, sd, 1'b0);
        end else if (scen == 1) begin
          for (int f = 0; f < RDTO; f++) begin
            if ($urandom_range(0, 1) == 1) pulse_status(nm, 16'($urandom), 1'b0);
            check("rnd_wait_busy", 32'(busy), 32'd1);
            pulse_frame();
          end
        end else begin
          repeat (RDTO - 1) pulse_frame();
          pulse_status({1'($urandom), a[6:0]}, sd, 1'b1);
        end
        check("rnd_done", 32'(rd_done), (scen != 1) ? (32'(1) << exp) : 32'd0);
        check("rnd_tmo", 32'(rd_timeout), (scen == 1) ? 32'd1 : 32'd0);
        check("rnd_data", 32'(rd_data), (scen == 1) ? 32'hFFFF : 32'(sd));
        check("rnd_idle", 32'(busy), 32'd0);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
